// File: rtl/video_pkg.sv
// Shared video types and default geometry for the scan doubler.
// RGB332 pixel layout and line buffer sizing.
package video_pkg;

   localparam int H_ACTIVE_DEF   = 256;
   localparam int IN_H_TOTAL_DEF = 384;
   localparam int BUF_AW         = $clog2(H_ACTIVE_DEF) + 1;

   typedef struct packed {
      logic [2:0] r;
      logic [2:0] g;
      logic [1:0] b;
   } rgb332_t;

endpackage

// File: rtl/line_buffer_dpram.sv
// Ping-pong line store: MSB of each address selects the bank.
// One write port, one registered read port, no reset on the array.
module line_buffer_dpram
   import video_pkg::*;
#(
   parameter int AW = BUF_AW,
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [DW-1:0] i_wdata,
   input  logic [AW-1:0] i_raddr,
   output logic [DW-1:0] o_rdata
);

   logic [DW-1:0] r_mem [0:(1<<AW)-1];

   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
      o_rdata <= r_mem[i_raddr];
   end

endmodule

// File: rtl/scan_doubler.sv
// Line doubler: captures a 15 kHz line into one bank while the
// previous line is replayed twice at double rate from the other.
module scan_doubler
   import video_pkg::*;
#(
   parameter int H_ACTIVE     = H_ACTIVE_DEF,
   parameter int IN_H_TOTAL   = IN_H_TOTAL_DEF,
   parameter int OUT_HS_START = 296,
   parameter int OUT_HS_LEN   = 32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pix_en,
   input  logic       in_valid,
   input  logic [2:0] in_r,
   input  logic [2:0] in_g,
   input  logic [1:0] in_b,
   input  logic       in_line_start,
   input  logic       in_vsync,
   output logic [2:0] out_r,
   output logic [2:0] out_g,
   output logic [1:0] out_b,
   output logic       out_de,
   output logic       out_hsync,
   output logic       out_vsync,
   output logic       overrun
);

   localparam int AW = $clog2(H_ACTIVE) + 1;
   localparam int CW = $clog2(IN_H_TOTAL + 1);

   localparam logic [CW-1:0] C_FULL = CW'(H_ACTIVE);
   localparam logic [CW-1:0] C_LAST = CW'(IN_H_TOTAL - 1);
   localparam logic [CW-1:0] C_HS0  = CW'(OUT_HS_START);
   localparam logic [CW-1:0] C_HS1  = CW'(OUT_HS_START + OUT_HS_LEN);

   logic          r_wr_bank;
   logic [CW-1:0] r_wr_addr;
   logic [CW-1:0] r_cnt [2];
   logic          r_overrun;

   logic          r_rd_bank;
   logic [CW-1:0] r_hcnt;
   logic          r_rep;
   logic          r_primed;
   logic          r_vsync_l;

   logic          r_de;
   logic          r_hs;
   logic          r_vs;

   logic          w_store;
   logic          w_full;
   logic          w_we;
   logic          w_de0;
   logic          w_hs0;
   logic [AW-1:0] w_waddr;
   logic [AW-1:0] w_raddr;
   logic [7:0]    w_rdata;
   rgb332_t       w_wpix;
   rgb332_t       w_rpix;

   assign w_store = pix_en & in_valid;
   assign w_full  = (r_wr_addr == C_FULL);

   // A strobe coinciding with line start lands at address 0 of the new bank
   assign w_we    = w_store & (in_line_start | ~w_full);
   assign w_waddr = in_line_start ? {~r_wr_bank, {(AW-1){1'b0}}}
                                  : {r_wr_bank, r_wr_addr[AW-2:0]};
   assign w_wpix  = {in_r, in_g, in_b};
   assign w_raddr = {r_rd_bank, r_hcnt[AW-2:0]};
   assign w_rpix  = rgb332_t'(w_rdata);

   line_buffer_dpram #(
      .AW (AW),
      .DW (8)
   ) u_buf (
      .clk     (clk),
      .i_we    (w_we),
      .i_waddr (w_waddr),
      .i_wdata (w_wpix),
      .i_raddr (w_raddr),
      .o_rdata (w_rdata)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_bank <= 1'b0;
         r_wr_addr <= '0;
         r_cnt[0]  <= '0;
         r_cnt[1]  <= '0;
         r_overrun <= 1'b0;
      end else begin
         r_overrun <= w_store & ~in_line_start & w_full;
         if (in_line_start) begin
            r_cnt[r_wr_bank] <= r_wr_addr;
            r_wr_bank        <= ~r_wr_bank;
            r_wr_addr        <= w_store ? CW'(1) : '0;
         end else if (w_store & ~w_full) begin
            r_wr_addr <= r_wr_addr + CW'(1);
         end
      end
   end

   // Resync on line start wins; second pass parks at the last count
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rd_bank <= 1'b0;
         r_hcnt    <= '0;
         r_rep     <= 1'b0;
         r_primed  <= 1'b0;
         r_vsync_l <= 1'b0;
      end else if (in_line_start) begin
         r_rd_bank <= r_wr_bank;
         r_hcnt    <= '0;
         r_rep     <= 1'b0;
         r_primed  <= 1'b1;
         r_vsync_l <= in_vsync;
      end else if (r_hcnt == C_LAST) begin
         if (!r_rep) begin
            r_hcnt <= '0;
            r_rep  <= 1'b1;
         end
      end else begin
         r_hcnt <= r_hcnt + CW'(1);
      end
   end

   assign w_de0 = r_primed & (r_hcnt < r_cnt[r_rd_bank]);
   assign w_hs0 = (r_hcnt >= C_HS0) & (r_hcnt < C_HS1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_de <= 1'b0;
         r_hs <= 1'b0;
         r_vs <= 1'b0;
      end else begin
         r_de <= w_de0;
         r_hs <= w_hs0;
         r_vs <= r_vsync_l;
      end
   end

   assign out_r     = r_de ? w_rpix.r : 3'd0;
   assign out_g     = r_de ? w_rpix.g : 3'd0;
   assign out_b     = r_de ? w_rpix.b : 2'd0;
   assign out_de    = r_de;
   assign out_hsync = r_hs;
   assign out_vsync = r_vs;
   assign overrun   = r_overrun;

endmodule

// File: tb/tb_scan_doubler.sv
// Directed bench for scan_doubler: each call drives one input line
// and records the doubled output of the previous line.
module tb_scan_doubler;

   localparam int LINE = 770;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       pix_en = 1'b0;
   logic       in_valid = 1'b0;
   logic [2:0] in_r = '0;
   logic [2:0] in_g = '0;
   logic [1:0] in_b = '0;
   logic       in_line_start = 1'b0;
   logic       in_vsync = 1'b0;
   logic [2:0] out_r;
   logic [2:0] out_g;
   logic [1:0] out_b;
   logic       out_de;
   logic       out_hsync;
   logic       out_vsync;
   logic       overrun;

   int checks = 0;
   int failures = 0;

   logic [7:0] slot_val [384];
   logic       slot_vld [384];
   logic [7:0] cur_mem [256];
   logic [7:0] nxt_mem [256];
   int         cur_cnt = 0;
   logic       vs_prev = 1'b0;

   logic [7:0] s_pix [LINE];
   logic       s_de  [LINE];
   logic       s_hs  [LINE];
   logic       s_vs  [LINE];
   logic       s_ov  [LINE];

   scan_doubler dut (
      .clk           (clk),
      .rst           (rst),
      .pix_en        (pix_en),
      .in_valid      (in_valid),
      .in_r          (in_r),
      .in_g          (in_g),
      .in_b          (in_b),
      .in_line_start (in_line_start),
      .in_vsync      (in_vsync),
      .out_r         (out_r),
      .out_g         (out_g),
      .out_b         (out_b),
      .out_de        (out_de),
      .out_hsync     (out_hsync),
      .out_vsync     (out_vsync),
      .overrun       (overrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int n_hi(input int lo, input int hi, input bit hs);
      int n = 0;
      for (int i = lo; i <= hi; i++)
         if ((hs ? s_hs[i] : s_de[i]) === 1'b1) n++;
      return n;
   endfunction

   function automatic logic [13:0] all_outs();
      return {out_r, out_g, out_b, out_de, out_hsync, out_vsync, overrun};
   endfunction

   task automatic fill(input int n, input int base, input int step,
                       input bit gaps);
      for (int p = 0; p < 384; p++) begin
         slot_vld[p] = (p < n) && !(gaps && (p % 3 == 2));
         slot_val[p] = 8'(base + p * step);
      end
   endtask

   // Pixel slot p is strobed at cycle 2p+1; cycle 0 carries line start.
   task automatic run_line(input string tag, input int len, input bit sim0,
                           input logic [7:0] sim_val, input logic vs);
      int n;
      int de_err;
      int px_err;
      int hs_err;
      int vs_err;
      int ov_n;
      n = 0;
      de_err = 0;
      px_err = 0;
      hs_err = 0;
      vs_err = 0;
      ov_n = 0;
      for (int c = 0; c < len; c++) begin
         @(negedge clk);
         s_pix[c] = {out_r, out_g, out_b};
         s_de[c]  = out_de;
         s_hs[c]  = out_hsync;
         s_vs[c]  = out_vsync;
         s_ov[c]  = overrun;
         in_line_start = (c == 0);
         in_vsync = vs;
         pix_en = 1'b0;
         in_valid = 1'b0;
         {in_r, in_g, in_b} = 8'h00;
         if (c == 0 && sim0) begin
            pix_en = 1'b1;
            in_valid = 1'b1;
            {in_r, in_g, in_b} = sim_val;
            nxt_mem[0] = sim_val;
            n = 1;
         end else if ((c % 2 == 1) && (c / 2 < 384)) begin
            pix_en = 1'b1;
            in_valid = slot_vld[c / 2];
            {in_r, in_g, in_b} = slot_val[c / 2];
            if (slot_vld[c / 2]) begin
               if (n < 256) nxt_mem[n] = slot_val[c / 2];
               n++;
            end
         end
      end
      for (int i = 1; i < len; i++) begin
         int k;
         int h;
         logic de_e;
         logic hs_e;
         logic vs_e;
         logic [7:0] px_e;
         vs_e = (i >= 2) ? vs : vs_prev;
         if (s_vs[i] !== vs_e) vs_err++;
         if (s_ov[i] === 1'b1) ov_n++;
         if (i >= 2) begin
            k = i - 2;
            h = (k < 768) ? (k % 384) : 383;
            de_e = (h < cur_cnt);
            px_e = de_e ? cur_mem[h] : 8'h00;
            hs_e = (h >= 296) && (h < 328);
            if (s_de[i] !== de_e) de_err++;
            if (s_pix[i] !== px_e) px_err++;
            if (s_hs[i] !== hs_e) hs_err++;
         end
      end
      chk({tag, " de"}, de_err, 0);
      chk({tag, " pix"}, px_err, 0);
      chk({tag, " hs"}, hs_err, 0);
      chk({tag, " vs"}, vs_err, 0);
      chk({tag, " ovr"}, ov_n, (n > 256) ? n - 256 : 0);
      for (int a = 0; a < 256; a++) cur_mem[a] = nxt_mem[a];
      cur_cnt = (n > 256) ? 256 : n;
      vs_prev = vs;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("reset_outs", all_outs(), 0);
      rst = 1'b0;

      fill(256, 0, 1, 0);
      run_line("ramp_in", LINE, 0, 8'h00, 1'b0);
      chk("unprimed_de", n_hi(0, LINE - 1, 0), 0);

      fill(300, 'h40, 1, 0);
      run_line("ovr_in", LINE, 0, 8'h00, 1'b0);
      chk("ramp_first", s_pix[2], 8'h00);
      chk("ramp_last", s_pix[257], 8'hFF);
      chk("ramp_end_de", s_de[258], 1'b0);
      chk("ramp_rep_first", s_pix[386], 8'h00);
      chk("ramp_rep_last", s_pix[641], 8'hFF);
      chk("ramp_de_total", n_hi(0, LINE - 1, 0), 512);

      fill(150, 5, 7, 1);
      run_line("short_in", LINE, 0, 8'h00, 1'b0);
      chk("ovr_last", s_pix[257], 8'h3F);
      chk("ovr_de_total", n_hi(0, LINE - 1, 0), 512);

      fill(10, 'h10, 1, 0);
      run_line("sim_in", LINE, 1, 8'hE3, 1'b0);
      chk("short_de_n", n_hi(2, 385, 0), 100);
      chk("short_gap", s_pix[4], 8'd26);
      chk("short_blank", s_pix[102], 8'h00);

      fill(256, 'hC0, 3, 0);
      run_line("pre_rs", LINE, 0, 8'h00, 1'b0);
      chk("sim_first", s_pix[2], 8'hE3);
      chk("sim_second", s_pix[3], 8'h10);
      chk("sim_rep_first", s_pix[386], 8'hE3);
      chk("sim_de_n", n_hi(2, 385, 0), 11);

      fill(20, 'hA0, 1, 0);
      run_line("resync", 201, 0, 8'h00, 1'b1);
      chk("vs_hold", s_vs[1], 1'b0);
      chk("vs_rise", s_vs[2], 1'b1);

      fill(256, 0, 5, 0);
      run_line("after_rs", LINE, 0, 8'h00, 1'b0);
      chk("rs_vs_held", s_vs[1], 1'b1);
      chk("rs_vs_fall", s_vs[2], 1'b0);
      chk("rs_hs_n", n_hi(0, LINE - 1, 1), 64);
      chk("rs_first", s_pix[2], 8'hA0);

      fill(0, 0, 0, 0);
      run_line("mid", 101, 0, 8'h00, 1'b0);
      @(negedge clk);
      chk("pre_rst_de", out_de, 1'b1);
      rst = 1'b1;
      pix_en = 1'b0;
      in_valid = 1'b0;
      in_line_start = 1'b0;
      in_vsync = 1'b0;
      #1;
      chk("mid_rst_outs", all_outs(), 0);
      repeat (2) @(negedge clk);
      chk("rst_hold_outs", all_outs(), 0);
      rst = 1'b0;
      cur_cnt = 0;
      vs_prev = 1'b0;

      fill(256, 'h33, 1, 0);
      run_line("post_rst", LINE, 0, 8'h00, 1'b0);
      chk("post_rst_de", n_hi(0, LINE - 1, 0), 0);

      fill(0, 0, 0, 0);
      run_line("post_rst2", LINE, 0, 8'h00, 1'b0);
      chk("post_rst_de2", s_de[2], 1'b1);
      chk("post_rst_pix", s_pix[2], 8'h33);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
